seg7_capture: RTL

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver: samples active-low `seg`/`an` scan lines and reconstructs the displayed time.
- Decodes each digit, checks it, and publishes hours/minutes as BCD and binary with a per-frame valid/error pulse.
- Used as an on-board loopback monitor and as the display checker in system benches.

---
 rtl/seg7_capture.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: receive-side monitor for a multiplexed 4-digit active-low
// seven-segment scan. The segment and anode lines are synchronized and each
// digit slot is debounced. Every digit is decoded and checked, and the
// reconstructed hh:mm is published as BCD and binary with a valid/error
// pulse for each frame. A stale flag shows when no frame has committed for a
// long time.
//
// Optional build macro SEG7_CAP_CONFIRM_EN: a good frame is published only
// if its digits repeat those of the previous good frame.
module seg7_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [0:6] seg,
    input  logic [3:0] an,
    output logic [2:0] hrs_tens,
    output logic [3:0] hrs_ones,
    output logic [2:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       stale
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [0:6]    seg_s1, seg_s2, seg_q;
    logic [3:0]    an_s1, an_s2, an_q;
    logic          pair_change;

    logic [SW-1:0] settle_cnt;
    logic          cap_done;
    logic          capture;

    logic          slot_ok;
    logic [1:0]    slot_idx;
    logic [3:0]    dig_val;
    logic          dig_blank;
    logic          dig_bad;
    logic          dig_err;

    logic [3:0]    slot_val [4];
    logic [3:0]    slot_err;
    logic [3:0]    mask;
    logic          commit;

    logic [6:0]    hrs_bin;
    logic [5:0]    mins_bin;
    logic          good;
    logic          publish;

    logic [TW-1:0] tcnt;

    // Two-flop synchronizers, then one extra stage so the settled pair can be
    // compared with the previous one.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            seg_q  <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
            an_q   <= '0;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            an_s1  <= an;
            an_s2  <= an_s1;
            an_q   <= an_s2;
        end
    end

    assign pair_change = (an_s2 != an_q) || (seg_s2 != seg_q);

    // Map the active-low one-hot anode to a slot; anything else is idle.
    always_comb begin
        slot_ok  = 1'b1;
        slot_idx = 2'd0;
        case (an_q)
            4'b0111: slot_idx = 2'd0;
            4'b1011: slot_idx = 2'd1;
            4'b1101: slot_idx = 2'd2;
            4'b1110: slot_idx = 2'd3;
            default: slot_ok  = 1'b0;
        endcase
    end

    // Decode active-low abcdefg (seg[0] = a) into a digit, blank or illegal.
    always_comb begin
        dig_val   = '0;
        dig_blank = 1'b0;
        dig_bad   = 1'b0;
        case (seg_q)
            7'b0000001: dig_val   = 4'd0;
            7'b1001111: dig_val   = 4'd1;
            7'b0010010: dig_val   = 4'd2;
            7'b0000110: dig_val   = 4'd3;
            7'b1001100: dig_val   = 4'd4;
            7'b0100100: dig_val   = 4'd5;
            7'b0100000: dig_val   = 4'd6;
            7'b0001111: dig_val   = 4'd7;
            7'b0000000: dig_val   = 4'd8;
            7'b0000100: dig_val   = 4'd9;
            7'b1111111: dig_blank = 1'b1;
            default:    dig_bad   = 1'b1;
        endcase
    end

    // Slot legality: hours tens is blank or 1 only, and minutes tens is 0..5.
    always_comb begin
        dig_err = 1'b0;
        case (slot_idx)
            2'd0:    dig_err = dig_bad || !(dig_blank || (dig_val == 4'd1));
            2'd2:    dig_err = dig_bad || dig_blank || (dig_val > 4'd5);
            default: dig_err = dig_bad || dig_blank;
        endcase
    end

    assign capture = slot_ok && !cap_done && (settle_cnt == SETTLE_LAST);

    // Stability counter: restarts on any change or on idle, and saturates.
    // The done flag blocks a second capture of the same stable pair.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            cap_done   <= 1'b0;
        end else if (pair_change || !slot_ok) begin
            settle_cnt <= '0;
            cap_done   <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_LAST) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (capture) begin
                cap_done <= 1'b1;
            end
        end
    end

    assign commit = &mask;

    // Per-slot capture store. A recapture before completion overwrites the
    // slot. The commit cycle clears the mask and the error bits.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                slot_val[i] <= '0;
            end
            slot_err <= '0;
            mask     <= '0;
        end else if (commit) begin
            slot_err <= '0;
            mask     <= '0;
        end else if (capture) begin
            slot_val[slot_idx] <= dig_val;
            slot_err[slot_idx] <= dig_err;
            mask[slot_idx]     <= 1'b1;
        end
    end

    assign hrs_bin  = 7'(slot_val[0]) * 7'd10 + 7'(slot_val[1]);
    assign mins_bin = 6'(slot_val[2]) * 6'd10 + 6'(slot_val[3]);
    assign good     = (slot_err == 4'b0000) && (hrs_bin >= 7'd1) && (hrs_bin <= 7'd12);

`ifdef SEG7_CAP_CONFIRM_EN
    logic [15:0] digits_now;
    logic [15:0] cand;
    logic        cand_valid;

    assign digits_now = {slot_val[0], slot_val[1], slot_val[2], slot_val[3]};
    assign publish    = good && cand_valid && (cand == digits_now);

    // Candidate frame: every good frame replaces it, and a bad frame drops it.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cand       <= '0;
            cand_valid <= 1'b0;
        end else if (commit) begin
            if (good) begin
                cand       <= digits_now;
                cand_valid <= 1'b1;
            end else begin
                cand_valid <= 1'b0;
            end
        end
    end
`else
    assign publish = good;
`endif

    // Frame commit: publish the time on a good frame, pulse an error otherwise.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hrs_tens    <= '0;
            hrs_ones    <= '0;
            mins_tens   <= '0;
            mins_ones   <= '0;
            hours       <= 4'd12;
            minutes     <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (commit && publish) begin
                hrs_tens    <= slot_val[0][2:0];
                hrs_ones    <= slot_val[1];
                mins_tens   <= slot_val[2][2:0];
                mins_ones   <= slot_val[3];
                hours       <= hrs_bin[3:0];
                minutes     <= mins_bin;
                frame_valid <= 1'b1;
            end
            if (commit && !good) begin
                frame_error <= 1'b1;
            end
        end
    end

    // Timeout counter: any commit clears it and wins over saturation.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (commit) begin
            tcnt <= '0;
        end else if (tcnt != TIMEOUT_MAX) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign stale = (tcnt == TIMEOUT_MAX);

endmodule
